// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - state encoding and default rates shared by the stopwatch chain
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_BAD   = 2'd3
   } sw_state_e;

   localparam int unsigned DEFAULT_CLK_FREQ_HZ     = 50_000_000;
   localparam int unsigned DEFAULT_TICK_HZ         = 100;
   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/stopwatch_tick_ctrl_if.sv
// rtl/stopwatch_tick_ctrl_if.sv - button inputs and tick/status outputs of the stopwatch front end
interface stopwatch_tick_ctrl_if;

   logic btn_start_stop;
   logic btn_clear;
   logic tick;
   logic counter_clear;
   logic running;
   logic paused;

   modport master (
      output btn_start_stop, btn_clear,
      input  tick, counter_clear, running, paused
   );

   modport slave (
      input  btn_start_stop, btn_clear,
      output tick, counter_clear, running, paused
   );

endinterface

// File: rtl/stopwatch_tick_ctrl_debounce.sv
// rtl/stopwatch_tick_ctrl_debounce.sv - 2-FF synchronizer, debounce filter and press pulse for one button
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic press
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q,   cnt_d;

   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_MAX) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Press fires on the edge where the accepted level is about to rise.
   assign press = sync2_q && !level_q && (cnt_q == CNT_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/stopwatch_tick_ctrl.sv
// rtl/stopwatch_tick_ctrl.sv - IDLE/RUN/PAUSE control and 100 Hz tick prescaler for the stopwatch chain
import stopwatch_pkg::*;

module stopwatch_tick_ctrl #(
   parameter int unsigned CLK_FREQ_HZ     = DEFAULT_CLK_FREQ_HZ,
   parameter int unsigned TICK_HZ         = DEFAULT_TICK_HZ,
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic                 clk,
   input  logic                 reset,
   stopwatch_tick_ctrl_if.slave bus
);

   localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;
   localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

   if (DIV < 2 || (CLK_FREQ_HZ % TICK_HZ) != 0) begin : g_param_check
      $error("stopwatch_tick_ctrl: CLK_FREQ_HZ must be an integer multiple >= 2 of TICK_HZ");
   end

   logic ss_press;
   logic clr_press;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start_stop (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (bus.btn_start_stop),
      .press   (ss_press)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (bus.btn_clear),
      .press   (clr_press)
   );

   sw_state_e     state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          tick_q, tick_d;
   logic          clear_q, clear_d;
   logic          running_q, running_d;
   logic          paused_q, paused_d;

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      clear_d = 1'b0;
      // Tick depends only on the current state, so a wrap on the edge leaving RUN is still emitted.
      tick_d  = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

      case (state_q)
         ST_IDLE: begin
            presc_d = '0;
            if (ss_press) state_d = ST_RUN;
         end
         ST_RUN: begin
            presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
            if (ss_press) state_d = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (ss_press) state_d = ST_RUN;
         end
         default: begin
            presc_d = '0;
            state_d = ST_IDLE;
         end
      endcase

      if (clr_press) begin
         state_d = ST_IDLE;
         presc_d = '0;
         clear_d = 1'b1;
      end

      running_d = (state_d == ST_RUN);
      paused_d  = (state_d == ST_PAUSE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         presc_q   <= '0;
         tick_q    <= 1'b0;
         clear_q   <= 1'b0;
         running_q <= 1'b0;
         paused_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         tick_q    <= tick_d;
         clear_q   <= clear_d;
         running_q <= running_d;
         paused_q  <= paused_d;
      end
   end

   assign bus.tick          = tick_q;
   assign bus.counter_clear = clear_q;
   assign bus.running       = running_q;
   assign bus.paused        = paused_q;

endmodule

// File: tb/tb_stopwatch_tick_ctrl.sv
// tb/tb_stopwatch_tick_ctrl.sv - directed bench with a tick scoreboard for stopwatch_tick_ctrl
module tb_stopwatch_tick_ctrl;

   logic clk;
   logic clk_en;
   logic reset;

   stopwatch_tick_ctrl_if bus ();

   stopwatch_tick_ctrl #(
      .CLK_FREQ_HZ     (1000),
      .TICK_HZ         (100),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 if (clk_en) clk = ~clk;

   int total;
   int bad;
   int cyc;
   int exp_q[$];
   int k, t, p, g, q, r, s, u, v;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: advance on posedge, sample on the following negedge.
   task automatic cycle();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      chk("run_pause_exclusive", int'(bus.running & bus.paused), 0);
      while (exp_q.size() > 0 && exp_q[0] < cyc) begin
         chk("tick_missed_cycle", -1, exp_q[0]);
         void'(exp_q.pop_front());
      end
      if (bus.tick === 1'b1) begin
         if (exp_q.size() == 0) chk("tick_spurious_cycle", cyc, -1);
         else chk("tick_cycle", cyc, exp_q.pop_front());
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic push_ticks(input int first, input int last);
      for (int tc = first; tc <= last; tc += 10) exp_q.push_back(tc);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      cyc   = 0;
      clk    = 1'b0;
      clk_en = 1'b0;
      reset  = 1'b0;
      bus.btn_start_stop = 1'b0;
      bus.btn_clear      = 1'b0;

      // Reset with the clock stopped
      #1 reset = 1'b1;
      #1;
      chk("rst_tick", int'(bus.tick), 0);
      chk("rst_counter_clear", int'(bus.counter_clear), 0);
      chk("rst_running", int'(bus.running), 0);
      chk("rst_paused", int'(bus.paused), 0);
      #5 reset = 1'b0;
      #1;
      chk("rel_running", int'(bus.running), 0);
      chk("rel_paused", int'(bus.paused), 0);
      clk_en = 1'b1;
      run(50);
      chk("idle_running", int'(bus.running), 0);
      chk("idle_paused", int'(bus.paused), 0);

      // Clear while already idle still pulses counter_clear
      bus.btn_clear = 1'b1;
      run(5);
      chk("idle_clr_early", int'(bus.counter_clear), 0);
      run(1);
      chk("idle_clr_pulse", int'(bus.counter_clear), 1);
      chk("idle_clr_running", int'(bus.running), 0);
      run(1);
      chk("idle_clr_width", int'(bus.counter_clear), 0);
      run(3);
      bus.btn_clear = 1'b0;
      run(8);

      // Start: running six cycles after the raw edge, ticks every 10
      k = cyc;
      bus.btn_start_stop = 1'b1;
      push_ticks(k + 16, k + 36);
      run(5);
      chk("start_running_early", int'(bus.running), 0);
      run(1);
      chk("start_running", int'(bus.running), 1);
      chk("start_paused", int'(bus.paused), 0);
      run(4);
      bus.btn_start_stop = 1'b0;
      run(26);

      // Pause with prescaler landing on 6, resume gives tick 4 cycles later
      t = cyc;
      bus.btn_start_stop = 1'b1;
      run(6);
      chk("pause_paused", int'(bus.paused), 1);
      chk("pause_running", int'(bus.running), 0);
      run(4);
      bus.btn_start_stop = 1'b0;
      run(36);
      chk("pause_hold", int'(bus.paused), 1);
      p = cyc;
      bus.btn_start_stop = 1'b1;
      push_ticks(p + 10, p + 30);
      run(6);
      chk("resume_running", int'(bus.running), 1);
      chk("resume_paused", int'(bus.paused), 0);
      run(4);
      bus.btn_start_stop = 1'b0;
      run(6);

      // Three-cycle glitch rejected, four-cycle press accepted
      g = cyc;
      bus.btn_start_stop = 1'b1;
      run(3);
      bus.btn_start_stop = 1'b0;
      run(10);
      chk("glitch_running", int'(bus.running), 1);
      chk("glitch_paused", int'(bus.paused), 0);
      q = cyc;
      bus.btn_start_stop = 1'b1;
      run(4);
      bus.btn_start_stop = 1'b0;
      run(2);
      chk("min_press_paused", int'(bus.paused), 1);
      chk("min_press_running", int'(bus.running), 0);
      run(6);
      r = cyc;
      bus.btn_start_stop = 1'b1;
      push_ticks(r + 11, r + 21);
      run(6);
      chk("resume2_running", int'(bus.running), 1);
      run(4);
      bus.btn_start_stop = 1'b0;
      run(11);

      // Simultaneous clear and start_stop: clear wins
      s = cyc;
      bus.btn_start_stop = 1'b1;
      bus.btn_clear      = 1'b1;
      run(5);
      chk("both_clr_early", int'(bus.counter_clear), 0);
      chk("both_running_early", int'(bus.running), 1);
      run(1);
      chk("both_running", int'(bus.running), 0);
      chk("both_paused", int'(bus.paused), 0);
      chk("both_clr_pulse", int'(bus.counter_clear), 1);
      run(1);
      chk("both_clr_width", int'(bus.counter_clear), 0);
      run(3);
      bus.btn_start_stop = 1'b0;
      bus.btn_clear      = 1'b0;
      run(30);
      chk("both_idle_running", int'(bus.running), 0);
      u = cyc;
      bus.btn_start_stop = 1'b1;
      push_ticks(u + 16, u + 16);
      run(6);
      chk("restart_running", int'(bus.running), 1);
      run(4);
      bus.btn_start_stop = 1'b0;
      run(9);

      // Asynchronous reset between clock edges
      #2 reset = 1'b1;
      #1;
      chk("async_running", int'(bus.running), 0);
      chk("async_paused", int'(bus.paused), 0);
      chk("async_tick", int'(bus.tick), 0);
      chk("async_counter_clear", int'(bus.counter_clear), 0);
      run(2);
      reset = 1'b0;
      run(1);
      chk("post_rst_running", int'(bus.running), 0);
      v = cyc;
      bus.btn_start_stop = 1'b1;
      push_ticks(v + 16, v + 36);
      run(5);
      chk("post_rst_running_early", int'(bus.running), 0);
      run(1);
      chk("post_rst_start", int'(bus.running), 1);
      run(4);
      bus.btn_start_stop = 1'b0;
      run(28);
      chk("ticks_outstanding", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stopwatch_tick_ctrl.md
Name: stopwatch_tick_ctrl

Overview:
Front-end control stage of the stopwatch chain: converts the board clock into the single-cycle 100 Hz enable that advances the hundredths-of-second decade counter. Debounces the start/stop and clear push-buttons and runs the IDLE/RUN/PAUSE state machine. Drives the clear pulse and status outputs consumed by the counter chain and status LEDs.

Parameters:
CLK_FREQ_HZ, 50000000, board clock frequency; must be an integer multiple of TICK_HZ.
TICK_HZ, 100, tick rate. DIV = CLK_FREQ_HZ/TICK_HZ, which must be at least 2; elaboration fails otherwise.
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a button level is accepted (20 ms at 50 MHz).

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  asynchronous, active-high reset
btn_start_stop  in  1  raw push-button, active-high, asynchronous to clk
btn_clear  in  1  raw push-button, active-high, asynchronous to clk
tick  out  1  one-cycle enable at TICK_HZ; only while RUN
counter_clear  out  1  one-cycle pulse commanding the downstream counters to zero
running  out  1  high in RUN
paused  out  1  high in PAUSE

Behaviour:
- One clock; reset is asynchronous and active-high, ports named clk and reset. While reset is high: state=IDLE, prescaler=0, all outputs 0, synchronizers and debouncers 0. Release takes effect at the next clk edge.
- Button path, per button:
  - 2-FF synchronizer.
  - Debounce counter: increments while the synced level differs from the accepted level and resets to 0 when they match. On reaching DEBOUNCE_CYCLES-1, the accepted level flips and the counter resets.
  - A press event is a one-cycle internal pulse on the accepted level's 0->1 transition. Release generates no event.
  - Latency from a clean raw edge to the press event: 2 + DEBOUNCE_CYCLES cycles.
- FSM states: IDLE (reset state), RUN, PAUSE.
  - start_stop press: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
  - clear press: any state->IDLE. counter_clear=1 for exactly the next cycle. Prescaler is forced to 0.
  - clear and start_stop pressed in the same cycle: clear wins, start_stop is discarded.
  - clear pressed while already IDLE: counter_clear still pulses.
- Prescaler: width $clog2(DIV).
  - Counts only in RUN. At DIV-1 it wraps to 0 on the next edge and tick is registered high for one cycle.
  - Holds its value in PAUSE, so fractional time is preserved. Is 0 in IDLE.
  - First tick after IDLE->RUN: tick is high in the cycle following the DIV-th edge after state becomes RUN.
  - Leaving RUN on the same edge that the prescaler wraps: that tick is still emitted (registered). No further ticks until RUN is re-entered.
- All outputs are registered; no combinational path from inputs to outputs.
- running/paused update on the same edge as the state. In IDLE both are 0. Never both 1.
- Reset asserted mid-operation: outputs drop to 0 immediately, without waiting for clk. A pending press event is lost.

Decomposition:
- Shared package stopwatch_pkg:
  - state encoding (ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2; 2'd3 recovers to IDLE)
  - default CLK_FREQ_HZ/TICK_HZ constants, reused by the downstream seconds/minutes counters.
- Sub-module button_debounce (synchronizer + debounce + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated twice.
- FSM and prescaler stay in the top.

Test Plan (CLK_FREQ_HZ=1000, TICK_HZ=100 -> DIV=10, DEBOUNCE_CYCLES=4):
1. Assert reset with the clock stopped, then release -> tick, counter_clear, running and paused are all 0 with no clk edge. State is IDLE, and no tick appears over 50 cycles.
2. Clean start_stop press held 10 cycles -> running=1 six cycles after the raw edge. tick is high one cycle at 10, 20, 30 cycles after running rises; exactly 1 cycle wide each time.
3. In RUN, press start_stop when the prescaler is at 6 -> paused=1 and no tick for 40 cycles. Press again -> running=1, and the first tick comes 4 cycles after running rises (prescaler resumed at 6).
4. Glitch on btn_start_stop high for 3 cycles, then low -> no state change. A press held for exactly 4 stable synced cycles is accepted.
5. In RUN, both buttons deliver press events in the same cycle -> IDLE, counter_clear high for exactly 1 cycle, running=paused=0, no further tick. The next start gives its first tick 10 cycles after entry.
6. Assert reset asynchronously mid-RUN, between clk edges -> all outputs 0 before the next edge. After release, state is IDLE and a start press behaves as in test 2.
